// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: control/status bundle between the multi-cycle FSM and the shared datapath
interface multicycle_controller_if;
  logic [6:0] op;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] imm_src;
  logic       reg_write;
  logic       illegal;
  logic [3:0] state_o;
  modport master (
    input  op, zero, mem_ready,
    output pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
           alu_src_b, alu_op, imm_src, reg_write, illegal, state_o
  );
  modport slave (
    output op, zero, mem_ready,
    input  pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
           alu_src_b, alu_op, imm_src, reg_write, illegal, state_o
  );
endinterface

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore control FSM sequencing the shared RV32 datapath over several cycles
module multicycle_controller (
  input logic                    clk,
  input logic                    reset,
  multicycle_controller_if.master bus
);
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_ALUWB    = 4'd7;
  localparam logic [3:0] S_EXECUTEI = 4'd8;
  localparam logic [3:0] S_JAL      = 4'd9;
  localparam logic [3:0] S_BEQ      = 4'd10;
  localparam logic [3:0] S_TRAP     = 4'd11;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  logic [3:0] state_q, state_d;
  logic       pc_write, ir_write, mem_write, reg_write, adr_src, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  always_ff @(posedge clk)
    state_q <= reset ? S_FETCH : state_d;
  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    adr_src    = 1'b0;
    illegal    = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    case (state_q)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        pc_write   = bus.mem_ready;
        ir_write   = bus.mem_ready;
        state_d    = bus.mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        state_d   = (bus.op == OP_LW || bus.op == OP_SW) ? S_MEMADR   :
                    bus.op == OP_R                     ? S_EXECUTER :
                    bus.op == OP_I                     ? S_EXECUTEI :
                    bus.op == OP_JAL                   ? S_JAL      :
                    bus.op == OP_BEQ                   ? S_BEQ      : S_TRAP;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = bus.op == OP_LW ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        state_d = bus.mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        state_d   = bus.mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECUTER: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
        state_d   = S_ALUWB;
      end
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        pc_write  = bus.zero;
        state_d   = S_FETCH;
      end
      S_TRAP: illegal = 1'b1;
      // unreachable encodings are treated as a fault and parked in TRAP
      default: state_d = S_TRAP;
    endcase
  end
  assign bus.pc_write   = pc_write & ~reset;
  assign bus.ir_write   = ir_write & ~reset;
  assign bus.mem_write  = mem_write & ~reset;
  assign bus.reg_write  = reg_write & ~reset;
  assign bus.adr_src    = adr_src;
  assign bus.illegal    = illegal;
  assign bus.result_src = result_src;
  assign bus.alu_src_a  = alu_src_a;
  assign bus.alu_src_b  = alu_src_b;
  assign bus.alu_op     = alu_op;
  assign bus.state_o    = state_q;
  assign bus.imm_src    = bus.op == OP_SW  ? 2'b01 :
                          bus.op == OP_BEQ ? 2'b10 :
                          bus.op == OP_JAL ? 2'b11 : 2'b00;
endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multi-cycle control FSM for the RV32 core. It sequences a shared datapath (one memory port, one ALU, PC, IR, ALUOut and data registers) over several cycles per instruction. It replaces single-cycle decode for the multi-cycle build and drives every mux select and write strobe. It supports lw, sw, R-type, I-type ALU, jal and beq, and provides a memory wait handshake and an illegal-opcode trap.

## Interface
No parameters.
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high; one clock, no other clocks
- op  input  7  opcode field of the instruction register (IR[6:0]), valid from DECODE onward
- zero  input  1  ALU zero flag, same cycle
- mem_ready  input  1  memory completes the current read/write this cycle
- pc_write  output  1  PC load enable
- adr_src  output  1  memory address select: 0 = PC, 1 = ALUOut
- mem_write  output  1  memory write strobe
- ir_write  output  1  IR and old-PC register load enable
- result_src  output  2  result select: 00 = ALUOut, 01 = memory data reg, 10 = ALU result
- alu_src_a  output  2  ALU A select: 00 = PC, 01 = old PC, 10 = rs1 register
- alu_src_b  output  2  ALU B select: 00 = rs2 register, 01 = immediate, 10 = constant 4
- alu_op  output  2  to ALU decoder: 00 = add, 01 = subtract (branch), 10 = funct-decoded
- imm_src  output  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J
- reg_write  output  1  register file write enable
- illegal  output  1  high while in TRAP
- state_o  output  4  current state encoding, for debug and verification

## Operation
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, ALUWB=7, EXECUTEI=8, JAL=9, BEQ=10, TRAP=11.
- Outputs are Moore-decoded from state. Exceptions: pc_write and ir_write are gated by mem_ready or zero, as listed below.
- Any output not listed for a state is 0.
- imm_src is decoded combinationally from op in every state:
  - 0000011 / 0010011 → 00
  - 0100011 → 01
  - 1100011 → 10
  - 1101111 → 11
  - any other opcode → 00
- FETCH:
  - adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10.
  - ir_write=pc_write=mem_ready.
  - Stays in FETCH until mem_ready, then goes to DECODE.
- DECODE: alu_src_a=01, alu_src_b=01, alu_op=00 (computes the branch target into ALUOut). Next state by op:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECUTER
  - 0010011 → EXECUTEI
  - 1101111 → JAL
  - 1100011 → BEQ
  - any other opcode → TRAP
- MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00. Goes to MEMREAD if op=0000011, otherwise MEMWRITE.
- MEMREAD: adr_src=1. Stays until mem_ready, then goes to MEMWB.
- MEMWB: result_src=01, reg_write=1. Goes to FETCH.
- MEMWRITE: adr_src=1, mem_write=1. mem_write is held until mem_ready; on mem_ready goes to FETCH.
- EXECUTER: alu_src_a=10, alu_src_b=00, alu_op=10. Goes to ALUWB.
- EXECUTEI: alu_src_a=10, alu_src_b=01, alu_op=10. Goes to ALUWB.
- ALUWB: result_src=00, reg_write=1. Goes to FETCH.
- JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1. Goes to ALUWB, which writes PC+4 to rd.
- BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, pc_write=zero. Goes to FETCH.
- TRAP: all strobes 0, illegal=1. Stays in TRAP until reset.

## Timing
- Reset:
  - While reset is high, all strobes (pc_write, mem_write, ir_write, reg_write) are forced to 0.
  - On the clock edge with reset high, state becomes FETCH; illegal clears to 0.
  - Mux selects follow state; after the reset edge they are the FETCH values.
- Reset mid-instruction abandons the instruction. No strobe fires in the cycle reset is high.
- Latency with mem_ready held at 1:
  - lw 5 cycles
  - sw, R-type, I-type, jal 4 cycles
  - beq 3 cycles
- Each mem_ready=0 cycle in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- pc_write and ir_write pulse for exactly one cycle per instruction in FETCH: the cycle mem_ready=1.
- mem_ready is ignored in all states other than FETCH, MEMREAD and MEMWRITE.
- zero is sampled only in BEQ.
- op is stable from DECODE until the next FETCH, because ir_write only fires in FETCH.

## Test plan
- Reset held 3 cycles with mem_ready=1, then released:
  - No strobe is asserted during reset.
  - state_o=0 on the first cycle after release.
  - pc_write=ir_write=1 in that cycle.
- lw (op=0000011) with mem_ready=1:
  - state_o sequence is 0,1,2,3,4,0.
  - reg_write=1 with result_src=01 only in state 4.
- sw (op=0100011) with mem_ready low for 2 cycles in MEMWRITE:
  - state_o sequence is 0,1,2,5,5,5,0.
  - mem_write=1 in all three state-5 cycles.
  - reg_write stays 0 throughout.
- beq (op=1100011):
  - With zero=1 in BEQ: pc_write=1 in state 10.
  - With zero=0: pc_write=0.
  - Both cases return to FETCH after 3 cycles.
- jal (op=1101111):
  - state_o sequence is 0,1,9,7,0.
  - pc_write=1 in state 9 and reg_write=1 in state 7.
  - imm_src=11 in state 1.
- Illegal opcode (op=1111111):
  - In DECODE, goes to TRAP; illegal=1 and all strobes stay 0 for 10 cycles.
  - Asserting reset returns the FSM to FETCH with illegal=0.
